lfsr_gen: RTL
=============

LFSR_GEN -- requirements
Module: lfsr_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning LFSR state width (legal 3..32).
REQ-002 SHALL have parameter TAPS, default 8'hB8, meaning WIDTH-bit feedback mask where bit i set includes state[i].
REQ-003 SHALL have parameter MODE, default 0, meaning 0 = Fibonacci and 1 = Galois.
REQ-004 SHALL have parameter CNT_W, default 16, meaning step/period counter width (CNT_W >= WIDTH).
REQ-005 SHALL have port clk  input  1  meaning the single system clock; all state changes on its rising edge.
REQ-006 SHALL have port rst  input  1  meaning reset, asynchronous and active-high.
REQ-007 SHALL have port en  input  1  meaning advance the LFSR one step this cycle.
REQ-008 SHALL have port load  input  1  meaning capture seed as the new state and start value.
REQ-009 SHALL have port seed  input  WIDTH  meaning the load value.
REQ-010 SHALL have port state  output  WIDTH  meaning the current LFSR register.
REQ-011 SHALL have port bit_out  output  1  meaning state[WIDTH-1].
REQ-012 SHALL have port step_cnt  output  CNT_W  meaning steps taken since the last load or wrap.
REQ-013 SHALL have port period  output  CNT_W  meaning the last measured sequence period.
REQ-014 SHALL have port period_done  output  1  meaning a one-cycle pulse when the sequence returns to its start value.
REQ-015 SHALL have port lockup  output  1  meaning a one-cycle pulse when an all-zero load was corrected.

Function
REQ-016 Fibonacci step SHALL compute fb = XOR of state[i] where TAPS[i]=1; next = {state[WIDTH-2:0], fb}.
REQ-017 Galois step SHALL compute msb = state[WIDTH-1]; next = {state[WIDTH-2:0],0} XOR (msb ? {TAPS[WIDTH-2:0],1} : 0).
REQ-018 Priority SHALL be rst > load > en; when load and en are both high, load only, with no step.
REQ-019 Load SHALL set state and start to seed, step_cnt to 0, and leave period unchanged, with 1-cycle latency (visible on the next edge).
REQ-020 Zero seed: a load of seed==0 SHALL set state and start to 1 and pulse lockup high for exactly the following cycle.
REQ-021 Each en step SHALL increment step_cnt, saturating at all-ones without wrapping.
REQ-022 Wrap: when an en step produces next == start, the block SHALL register period <= step_cnt+1 and step_cnt <= 0, and pulse period_done for one cycle.
REQ-023 en low and load low SHALL hold all registers; period_done and lockup SHALL be 0.
REQ-024 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-025 rst high SHALL immediately force state=1, start=1, step_cnt=0, period=0, period_done=0, lockup=0, including mid-sequence.
REQ-026 After rst deasserts, the first en step SHALL proceed from state=1.

Structure
REQ-027 The shared package SHALL hold the MODE encodings (MODE_FIB=0, MODE_GAL=1) and default maximal tap masks per width (8: B8, 16: B400, 32: 80200003).
REQ-028 The next-state function SHALL be one combinational sub-module, lfsr_next (WIDTH, TAPS, MODE), instantiated once; counters and compare stay in lfsr_gen.

Verification
REQ-029 Defaults (Fibonacci), rst then en=1 from state 0x01 -> state sequence 0x02, 0x04, 0x08, 0x11.
REQ-030 Defaults, load seed 0x01 then en=1 for 255 cycles -> period_done pulses on step 255, period=255, step_cnt=0.
REQ-031 MODE=1, load seed 0x01, en=1 for 255 cycles -> period_done on step 255, period=255; first step gives 0x02, and the step from 0x80 gives 0x71.
REQ-032 Load seed 0x00 -> state=0x01 next cycle, lockup high exactly 1 cycle.
REQ-033 load=1 and en=1 in the same cycle with seed 0x5A -> state=0x5A, step_cnt=0, no step.
REQ-034 Assert rst asynchronously at step 100 -> state=0x01 and all counters 0 before the next clk edge.

Source files
------------

// File: rtl/lfsr_gen_pkg.sv
// ---------------------------------------------------------------------------
// lfsr_gen_pkg : mode encodings and default maximal-length tap masks.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package lfsr_gen_pkg;

   localparam int MODE_FIB = 0;
   localparam int MODE_GAL = 1;

   localparam logic [7:0]  TAPS_W8  = 8'hB8;
   localparam logic [15:0] TAPS_W16 = 16'hB400;
   localparam logic [31:0] TAPS_W32 = 32'h8020_0003;

   // Widths without a table entry get a non-zero generic mask; override TAPS for those.
   function automatic logic [31:0] default_taps(input int w);
      case (w)
         8:       return {24'h0, TAPS_W8};
         16:      return {16'h0, TAPS_W16};
         32:      return TAPS_W32;
         default: return 32'h0000_0001 | (32'h1 << (w - 1));
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/lfsr_next.sv
// ---------------------------------------------------------------------------
// lfsr_next : combinational one-step LFSR next-state (Fibonacci or Galois).
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module lfsr_next
   import lfsr_gen_pkg::*;
#(
   parameter int               WIDTH = 8,
   parameter logic [WIDTH-1:0] TAPS  = WIDTH'(default_taps(WIDTH)),
   parameter int               MODE  = MODE_FIB
) (
   input  logic [WIDTH-1:0] cur_i,
   output logic [WIDTH-1:0] nxt_o
);

   generate
      if (MODE == MODE_GAL) begin : g_galois
         logic [WIDTH-1:0] w_mask;
         assign w_mask = cur_i[WIDTH-1] ? {TAPS[WIDTH-2:0], 1'b1} : '0;
         assign nxt_o  = {cur_i[WIDTH-2:0], 1'b0} ^ w_mask;
      end else begin : g_fib
         logic w_fb;
         assign w_fb  = ^(cur_i & TAPS);
         assign nxt_o = {cur_i[WIDTH-2:0], w_fb};
      end
   endgenerate

endmodule

`default_nettype wire

// File: rtl/lfsr_gen.sv
// ---------------------------------------------------------------------------
// lfsr_gen : LFSR with seed load, zero-seed correction and period measurement.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module lfsr_gen
   import lfsr_gen_pkg::*;
#(
   parameter int               WIDTH = 8,
   parameter logic [WIDTH-1:0] TAPS  = WIDTH'(default_taps(WIDTH)),
   parameter int               MODE  = MODE_FIB,
   parameter int               CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] seed,
   output logic [WIDTH-1:0] state,
   output logic             bit_out,
   output logic [CNT_W-1:0] step_cnt,
   output logic [CNT_W-1:0] period,
   output logic             period_done,
   output logic             lockup
);

   localparam logic [WIDTH-1:0] c_one   = WIDTH'(1);
   localparam logic [CNT_W-1:0] c_cnt_1 = CNT_W'(1);

   logic [WIDTH-1:0] state_q, state_d;
   logic [WIDTH-1:0] start_q, start_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic             done_q, done_d;
   logic             lock_q, lock_d;
   logic [WIDTH-1:0] w_nxt;

   lfsr_next #(
      .WIDTH (WIDTH),
      .TAPS  (TAPS),
      .MODE  (MODE)
   ) u_next (
      .cur_i (state_q),
      .nxt_o (w_nxt)
   );

   always_comb begin
      state_d  = state_q;
      start_d  = start_q;
      cnt_d    = cnt_q;
      period_d = period_q;
      done_d   = 1'b0;
      lock_d   = 1'b0;
      if (load) begin
         // An all-zero state would lock the register, so it is replaced by 1.
         if (seed == '0) begin
            state_d = c_one;
            start_d = c_one;
            lock_d  = 1'b1;
         end else begin
            state_d = seed;
            start_d = seed;
         end
         cnt_d = '0;
      end else if (en) begin
         state_d = w_nxt;
         if (w_nxt == start_q) begin
            period_d = cnt_q + c_cnt_1;
            cnt_d    = '0;
            done_d   = 1'b1;
         end else if (cnt_q != '1) begin
            cnt_d = cnt_q + c_cnt_1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= c_one;
         start_q  <= c_one;
         cnt_q    <= '0;
         period_q <= '0;
         done_q   <= 1'b0;
         lock_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         start_q  <= start_d;
         cnt_q    <= cnt_d;
         period_q <= period_d;
         done_q   <= done_d;
         lock_q   <= lock_d;
      end
   end

   assign state       = state_q;
   assign bit_out     = state_q[WIDTH-1];
   assign step_cnt    = cnt_q;
   assign period      = period_q;
   assign period_done = done_q;
   assign lockup      = lock_q;

endmodule

`default_nettype wire
